npc_bpu: RTL

Parametrised next-PC unit for the pipelined core. It owns the fetch PC register and predicts the next fetch address through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It takes branch and jump resolutions from EX, raises `flush` on a misprediction, and redirects fetch to the correct address. It sits between IF (driving `pc`) and EX (consuming resolution results).

---
 rtl/npc_bpu_pkg.sv | 14 +
 rtl/npc_btb.sv | 72 +++++++
 rtl/npc_bpu.sv | 63 ++++++
 3 files changed

// File: rtl/npc_bpu_pkg.sv
// npc_bpu_pkg: shared branch-predictor encodings and reset defaults
package npc_bpu_pkg;
  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;
  localparam logic [31:0] BP_RESET_PC = 32'h0000_0000;
  function automatic bp_ctr_e ctr_step(bp_ctr_e c, logic up);
    return up ? ((c == BP_ST) ? BP_ST : bp_ctr_e'(c + 2'd1))
              : ((c == BP_SNT) ? BP_SNT : bp_ctr_e'(c - 2'd1));
  endfunction
endpackage

// File: rtl/npc_btb.sv
// npc_btb: direct-mapped branch target buffer with 2-bit saturating counters
//   rd_pc -> rd_taken/rd_tgt : combinational lookup (old contents on same-cycle write)
//   wr_*                     : one resolution write port from EX
module npc_btb
  import npc_bpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_tgt,
  input  logic            wr_en,
  input  logic            wr_taken,
  input  logic            wr_jal,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_tgt
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = XLEN - IDX - 2;
  logic [ENTRIES-1:0] valid_q, valid_d, jal_q, jal_d;
  bp_ctr_e            ctr_q [ENTRIES];
  bp_ctr_e            ctr_d [ENTRIES];
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [TW-1:0]      tag_d [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [XLEN-1:0]    tgt_d [ENTRIES];
  logic [IDX-1:0]     ri, wi;
  logic [TW-1:0]      rt, wt;
  logic               wr_hit;
  assign ri       = rd_pc[IDX+1:2];
  assign rt       = rd_pc[XLEN-1:IDX+2];
  assign wi       = wr_pc[IDX+1:2];
  assign wt       = wr_pc[XLEN-1:IDX+2];
  assign rd_taken = valid_q[ri] & (tag_q[ri] == rt) & (jal_q[ri] | ctr_q[ri][1]);
  assign rd_tgt   = tgt_q[ri];
  assign wr_hit   = valid_q[wi] & (tag_q[wi] == wt);
  // A taken miss allocates (evicting any alias); a not-taken miss leaves the entry alone.
  always_comb begin
    valid_d = valid_q;
    jal_d   = jal_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (wr_en & (wr_taken | wr_hit))
      ctr_d[wi] = wr_hit ? ctr_step(ctr_q[wi], wr_taken) : (wr_jal ? BP_ST : BP_WT);
    if (wr_en & wr_taken) begin
      valid_d[wi] = 1'b1;
      tgt_d[wi]   = wr_tgt;
      if (!wr_hit) begin
        tag_d[wi] = wt;
        jal_d[wi] = wr_jal;
      end
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_WNT;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  // Payload is meaningless while valid is clear, so it carries no reset.
  always_ff @(posedge clk) begin
    jal_q <= jal_d;
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end
endmodule

// File: rtl/npc_bpu.sv
// npc_bpu: fetch PC register with BTB-based next-PC prediction and EX redirect
//   pc/pred_taken/pred_target : current fetch PC and its zero-latency prediction
//   ex_*                      : branch/jump resolution from EX
//   flush/mispred_cnt         : misprediction squash and saturating flush count
module npc_bpu
  import npc_bpu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(BP_RESET_PC)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_br,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush,
  output logic [31:0]     mispred_cnt
);
  logic [XLEN-1:0] pc_q, pc_d, act_next, pred_next;
  logic [31:0]     cnt_q, cnt_d;
  assign pc          = pc_q;
  assign mispred_cnt = cnt_q;
  // JALR is excluded from the write port so it is never predicted.
  npc_btb #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES)) u_btb (
    .clk      (clk),
    .rstn     (rstn),
    .rd_pc    (pc_q),
    .rd_taken (pred_taken),
    .rd_tgt   (pred_target),
    .wr_en    (ex_valid & (ex_is_br | ex_is_jal)),
    .wr_taken (ex_taken),
    .wr_jal   (ex_is_jal),
    .wr_pc    (ex_pc),
    .wr_tgt   (ex_target)
  );
  // Redirect beats stall: the squashed instructions behind EX are what stalled.
  always_comb begin
    act_next  = ex_taken ? ex_target : ex_pc + XLEN'(4);
    pred_next = ex_pred_taken ? ex_pred_target : ex_pc + XLEN'(4);
    flush     = ex_valid & (ex_is_br | ex_is_jal | ex_is_jalr) & (act_next != pred_next);
    pc_d      = flush ? act_next : stall ? pc_q : pred_taken ? pred_target : pc_q + XLEN'(4);
    cnt_d     = (flush & ~&cnt_q) ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
endmodule
